rename_queue: RTL
=================

# rename_queue

Parametrised rename/dispatch stage with a DEPTH-entry in-order dispatch buffer between decode and the reservation stations (exers, lsq, csr). On accept, it looks up both sources in the RAT and forms operands. Queued entries snoop the CDB to pick up tag results. It dispatches the oldest entry to its target station when that station is not stalled. Decode therefore stalls only when the buffer is full.

## Interface
- XLEN, 32, datapath width
- ROBID_W, 8, ROB tag width; a tag is carried in the low ROBID_W bits of an operand
- OP_W, 5, micro-op width
- RD_W, 6, destination field width
- DEPTH, 4, buffer entries, power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- decode_valid  in  1  decode offers an instruction
- decode_ready  out  1  buffer can accept; `!full && !rst`
- decode_addr  in  XLEN-2  PC[XLEN-1:2]
- decode_op / decode_robid / decode_rd  in  OP_W / ROBID_W / RD_W  micro-op, ROB tag, destination
- decode_uses_rs1, _uses_rs2, _uses_imm, _uses_memory, _uses_pc, _csr_access  in  1 each  decode flags
- decode_rs1, decode_rs2  in  5  source architectural registers
- decode_imm  in  XLEN  immediate
- rat_valid  out  1  `decode_valid & decode_ready & !rob_flush`
- rat_rd / rat_robid / rat_rs1 / rat_rs2  out  RD_W / ROBID_W / 5 / 5  decode fields passed through
- rat_rs1_valid, rat_rs2_valid  in  1  RAT value ready (same-cycle response)
- rat_rs1_tagval, rat_rs2_tagval  in  XLEN  value or tag
- cdb_valid  in  1  result broadcast
- cdb_robid  in  ROBID_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- disp_exers_write, disp_lsq_write, disp_csr_write  out  1  one-hot dispatch strobe
- disp_op, disp_robid, disp_rd, disp_imm  out  OP_W / ROBID_W / RD_W / XLEN  head entry fields
- disp_op1ready, disp_op2ready  out  1  operand ready flags
- disp_op1, disp_op2  out  XLEN  operand value or tag
- exers_stall, lsq_stall, csr_stall  in  1  station full
- rob_flush  in  1  pipeline flush

## Operation
- **Accept.** An instruction is accepted when `decode_valid & decode_ready & !rob_flush`. It is written at the tail pointer and the count is incremented.
- **Class.** `uses_memory` selects LSQ. Otherwise `csr_access` selects CSR. Otherwise the class is EXE.
- **Operand formation** by {uses_rs1, uses_pc}:
  - 00: op1 = imm (ready); op2 = 0 (ready).
  - 01: op1 = {addr, 2'b00} (ready); op2 = imm (ready).
  - 10: op1 = RAT rs1 value/tag with its ready flag.
    - If uses_rs2: op2 = RAT rs2 value/tag with its ready flag.
    - Else if uses_imm: op2 = imm (ready).
    - Else: op2 = 0 (ready).
  - 11: both operands are 0 and ready (deterministic; no X).
- **Enqueue-time capture.** If a not-ready operand's tag matches cdb_robid while cdb_valid is high, the operand stores cdb_value as ready.
- **Snoop.** Every cycle, each valid entry with opNready=0 and tag==cdb_robid while cdb_valid captures cdb_value and sets ready.
- **Dispatch.** The head entry dispatches when the queue is non-empty, rob_flush is low, and the stall input for its class is low. Exactly one write strobe is raised, the head pointer advances, and the count is decremented.
  - An EXE head blocked by exers_stall blocks everything behind it; dispatch is strictly in order.
- **Head operand bypass.** disp_op1/op2 and their ready flags are head storage merged with this cycle's CDB match. The dispatched operand is therefore never stale.
- **Simultaneous enqueue and dequeue** when not full: the count is unchanged and both pointers advance. When full, decode_ready=0 even if the head dispatches this cycle.
- **Flush.** rob_flush clears the count and both pointers in the same cycle. There are no writes, no accept, and rat_valid=0 that cycle.
- **Arithmetic.** Pointers are $clog2(DEPTH) bits and wrap naturally. The count is $clog2(DEPTH+1) bits.

## Timing
- **Reset.** Count, pointers and entry valid bits are 0. All disp_*_write and rat_valid are 0. decode_ready is 0 during rst and 1 in the cycle after. Data outputs are 0 when the queue is empty.
- **Latency.** An instruction accepted in cycle N can dispatch no earlier than cycle N+1. A full-queue stall releases decode_ready one cycle after a dispatch.
- **RAT.** The RAT response is combinational in the accept cycle. Operands are registered at the end of that cycle.
- **CDB.** A broadcast in cycle N is visible on the head outputs in cycle N (bypass) and is stored from N+1.
- **Reset mid-operation** discards all entries with no dispatch in the rst cycle.

## Configuration
- **RENAME_CDB_SNOOP_EN defined:** enqueue-time capture, per-entry snoop and head bypass are all implemented as above.
- **RENAME_CDB_SNOOP_EN undefined:**
  - Operands keep the RAT result as captured at accept; cdb_* inputs are unused.
  - The reservation stations are responsible for wakeup, including a CDB broadcast coincident with dispatch.

## Structure
- **Shared package `rename_pkg`:**
  - enum `disp_class_t` {DISP_EXE, DISP_LSQ, DISP_CSR}.
  - struct `rename_entry_t` {op, robid, rd, imm, op1ready, op1, op2ready, op2, class}.
  - Localparams for flag encodings.
- **Sub-module `rename_operand_sel`:** combinational operand formation plus enqueue-time CDB capture.
- **Top:** owns the FIFO storage, pointers, snoop logic and dispatch control.

## Test plan
- **Reset:** hold rst 2 cycles with decode_valid=1 → decode_ready=0, rat_valid=0, all writes 0; one cycle after release decode_ready=1.
- **Fill and drain:** exers_stall=1, enqueue 4 ADDI (imm=5) → 5th offer has decode_ready=0. Drop stall → 4 consecutive disp_exers_write with op2=5, op2ready=1, robids in order.
- **Snoop:** enqueue ADD with rs1 tag 0x12 not ready, head blocked. Next cycle cdb_valid, robid 0x12, value 0xDEADBEEF → after unblock, disp_op1=0xDEADBEEF, op1ready=1. Repeat with CDB in the dispatch cycle → same result through the bypass.
- **In-order blocking:** head is LSQ with lsq_stall=1, an EXE entry behind it, exers_stall=0 → no writes until lsq_stall drops, then LSQ dispatches, then EXE.
- **Flush:** 3 queued entries, rob_flush=1 with decode_valid=1 → no writes, rat_valid=0; next cycle queue empty, decode_ready=1.
- **Operand modes:** AUIPC addr=0x100 (word), imm=0x1000 → op1=0x400, op2=0x1000. LUI imm=0xABCDE000 → op1=imm, op2=0.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and encodings for the rename/dispatch queue.
// Optional build macro: RENAME_CDB_SNOOP_EN (operands pick up CDB results while queued).
package rename_pkg;

    // Default datapath widths; the queue entry struct is laid out with these.
    localparam int XLEN_P    = 32;
    localparam int ROBID_W_P = 8;
    localparam int OP_W_P    = 5;
    localparam int RD_W_P    = 6;

    // Operand-formation selector, encoded as {uses_rs1, uses_pc}.
    localparam logic [1:0] OPSEL_IMM  = 2'b00;
    localparam logic [1:0] OPSEL_PC   = 2'b01;
    localparam logic [1:0] OPSEL_RS   = 2'b10;
    localparam logic [1:0] OPSEL_BOTH = 2'b11;

    typedef enum logic [1:0] {
        DISP_EXE = 2'd0,
        DISP_LSQ = 2'd1,
        DISP_CSR = 2'd2
    } disp_class_t;

    typedef struct packed {
        logic [OP_W_P-1:0]    op;
        logic [ROBID_W_P-1:0] robid;
        logic [RD_W_P-1:0]    rd;
        logic [XLEN_P-1:0]    imm;
        logic                 op1ready;
        logic [XLEN_P-1:0]    op1;
        logic                 op2ready;
        logic [XLEN_P-1:0]    op2;
        disp_class_t          cls;
    } rename_entry_t;

    // Memory ops win over CSR access; everything else goes to the execute stations.
    function automatic disp_class_t classify(input logic uses_memory, input logic csr_access);
        if (uses_memory) begin
            return DISP_LSQ;
        end else if (csr_access) begin
            return DISP_CSR;
        end
        return DISP_EXE;
    endfunction

endpackage

// File: rtl/rename_operand_sel.sv
// Combinational operand formation for a decoded instruction, including
// capture of a CDB result that arrives in the accept cycle.
// Optional build macro: RENAME_CDB_SNOOP_EN.
module rename_operand_sel
    import rename_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 8
) (
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic              uses_imm,
    input  logic              uses_pc,
    input  logic [XLEN-3:0]   addr,
    input  logic [XLEN-1:0]   imm,
    input  logic              rs1_valid,
    input  logic [XLEN-1:0]   rs1_tagval,
    input  logic              rs2_valid,
    input  logic [XLEN-1:0]   rs2_tagval,
    input  logic              cdb_valid,
    input  logic [ROBID_W-1:0] cdb_robid,
    input  logic [XLEN-1:0]   cdb_value,
    output logic              op1ready,
    output logic [XLEN-1:0]   op1,
    output logic              op2ready,
    output logic [XLEN-1:0]   op2
);

    logic              raw1_ready;
    logic [XLEN-1:0]   raw1;
    logic              raw2_ready;
    logic [XLEN-1:0]   raw2;

    // Pick operand sources from the decode flags; the illegal rs1+pc combination yields zeros.
    always_comb begin
        raw1_ready = 1'b1;
        raw1       = '0;
        raw2_ready = 1'b1;
        raw2       = '0;
        case ({uses_rs1, uses_pc})
            OPSEL_IMM: begin
                raw1 = imm;
            end
            OPSEL_PC: begin
                raw1 = {addr, 2'b00};
                raw2 = imm;
            end
            OPSEL_RS: begin
                raw1_ready = rs1_valid;
                raw1       = rs1_tagval;
                if (uses_rs2) begin
                    raw2_ready = rs2_valid;
                    raw2       = rs2_tagval;
                end else if (uses_imm) begin
                    raw2 = imm;
                end
            end
            default: begin
                raw1 = '0;
                raw2 = '0;
            end
        endcase
    end

`ifdef RENAME_CDB_SNOOP_EN
    // A tag resolved on the CDB in the accept cycle is stored as a value straight away.
    always_comb begin
        op1ready = raw1_ready;
        op1      = raw1;
        op2ready = raw2_ready;
        op2      = raw2;
        if (cdb_valid && !raw1_ready && raw1[ROBID_W-1:0] == cdb_robid) begin
            op1ready = 1'b1;
            op1      = cdb_value;
        end
        if (cdb_valid && !raw2_ready && raw2[ROBID_W-1:0] == cdb_robid) begin
            op2ready = 1'b1;
            op2      = cdb_value;
        end
    end
`else
    // Wakeup is left to the reservation stations; the RAT result passes through as-is.
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_robid, cdb_value};

    always_comb begin
        op1ready = raw1_ready;
        op1      = raw1;
        op2ready = raw2_ready;
        op2      = raw2;
    end
`endif

endmodule

// File: rtl/rename_queue.sv
// Rename/dispatch stage: in-order buffer between decode and the reservation
// stations. Sources are looked up in the RAT at accept; the oldest entry is
// dispatched to its station whenever that station is not stalled.
// Optional build macro: RENAME_CDB_SNOOP_EN (enqueue capture, per-entry snoop, head bypass).
module rename_queue
    import rename_pkg::*;
#(
    parameter int XLEN    = XLEN_P,
    parameter int ROBID_W = ROBID_W_P,
    parameter int OP_W    = OP_W_P,
    parameter int RD_W    = RD_W_P,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               decode_valid,
    output logic               decode_ready,
    input  logic [XLEN-3:0]    decode_addr,
    input  logic [OP_W-1:0]    decode_op,
    input  logic [ROBID_W-1:0] decode_robid,
    input  logic [RD_W-1:0]    decode_rd,
    input  logic               decode_uses_rs1,
    input  logic               decode_uses_rs2,
    input  logic               decode_uses_imm,
    input  logic               decode_uses_memory,
    input  logic               decode_uses_pc,
    input  logic               decode_csr_access,
    input  logic [4:0]         decode_rs1,
    input  logic [4:0]         decode_rs2,
    input  logic [XLEN-1:0]    decode_imm,
    output logic               rat_valid,
    output logic [RD_W-1:0]    rat_rd,
    output logic [ROBID_W-1:0] rat_robid,
    output logic [4:0]         rat_rs1,
    output logic [4:0]         rat_rs2,
    input  logic               rat_rs1_valid,
    input  logic               rat_rs2_valid,
    input  logic [XLEN-1:0]    rat_rs1_tagval,
    input  logic [XLEN-1:0]    rat_rs2_tagval,
    input  logic               cdb_valid,
    input  logic [ROBID_W-1:0] cdb_robid,
    input  logic [XLEN-1:0]    cdb_value,
    output logic               disp_exers_write,
    output logic               disp_lsq_write,
    output logic               disp_csr_write,
    output logic [OP_W-1:0]    disp_op,
    output logic [ROBID_W-1:0] disp_robid,
    output logic [RD_W-1:0]    disp_rd,
    output logic [XLEN-1:0]    disp_imm,
    output logic               disp_op1ready,
    output logic               disp_op2ready,
    output logic [XLEN-1:0]    disp_op1,
    output logic [XLEN-1:0]    disp_op2,
    input  logic               exers_stall,
    input  logic               lsq_stall,
    input  logic               csr_stall,
    input  logic               rob_flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rename_entry_t      mem_q     [DEPTH];
    rename_entry_t      mem_d     [DEPTH];
    rename_entry_t      snp_entry [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full;
    logic               empty;
    logic               accept;
    logic               dispatch;
    logic               head_stall;
    rename_entry_t      head_e;
    rename_entry_t      new_entry;
    logic               new_op1ready, new_op2ready;
    logic [XLEN-1:0]    new_op1, new_op2;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign decode_ready = !full && !rst;
    assign accept       = decode_valid && decode_ready && !rob_flush;
    assign rat_valid    = accept;
    assign rat_rd       = decode_rd;
    assign rat_robid    = decode_robid;
    assign rat_rs1      = decode_rs1;
    assign rat_rs2      = decode_rs2;

    rename_operand_sel #(
        .XLEN    (XLEN),
        .ROBID_W (ROBID_W)
    ) u_operand_sel (
        .uses_rs1   (decode_uses_rs1),
        .uses_rs2   (decode_uses_rs2),
        .uses_imm   (decode_uses_imm),
        .uses_pc    (decode_uses_pc),
        .addr       (decode_addr),
        .imm        (decode_imm),
        .rs1_valid  (rat_rs1_valid),
        .rs1_tagval (rat_rs1_tagval),
        .rs2_valid  (rat_rs2_valid),
        .rs2_tagval (rat_rs2_tagval),
        .cdb_valid  (cdb_valid),
        .cdb_robid  (cdb_robid),
        .cdb_value  (cdb_value),
        .op1ready   (new_op1ready),
        .op1        (new_op1),
        .op2ready   (new_op2ready),
        .op2        (new_op2)
    );

    // Assemble the entry written at the tail on accept.
    always_comb begin
        new_entry          = '0;
        new_entry.op       = decode_op;
        new_entry.robid    = decode_robid;
        new_entry.rd       = decode_rd;
        new_entry.imm      = decode_imm;
        new_entry.op1ready = new_op1ready;
        new_entry.op1      = new_op1;
        new_entry.op2ready = new_op2ready;
        new_entry.op2      = new_op2;
        new_entry.cls      = classify(decode_uses_memory, decode_csr_access);
    end

    // Per-entry CDB snoop: waiting operands whose tag is broadcast become ready values.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_snoop
`ifdef RENAME_CDB_SNOOP_EN
            always_comb begin
                snp_entry[gi] = mem_q[gi];
                if (valid_q[gi] && cdb_valid) begin
                    if (!mem_q[gi].op1ready && mem_q[gi].op1[ROBID_W-1:0] == cdb_robid) begin
                        snp_entry[gi].op1ready = 1'b1;
                        snp_entry[gi].op1      = cdb_value;
                    end
                    if (!mem_q[gi].op2ready && mem_q[gi].op2[ROBID_W-1:0] == cdb_robid) begin
                        snp_entry[gi].op2ready = 1'b1;
                        snp_entry[gi].op2      = cdb_value;
                    end
                end
            end
`else
            assign snp_entry[gi] = mem_q[gi];
`endif
        end
    endgenerate

    // Head view with same-cycle CDB bypass, stall lookup and dispatch strobes.
    always_comb begin
        head_e = mem_q[head_q];
`ifdef RENAME_CDB_SNOOP_EN
        if (cdb_valid && !head_e.op1ready && head_e.op1[ROBID_W-1:0] == cdb_robid) begin
            head_e.op1ready = 1'b1;
            head_e.op1      = cdb_value;
        end
        if (cdb_valid && !head_e.op2ready && head_e.op2[ROBID_W-1:0] == cdb_robid) begin
            head_e.op2ready = 1'b1;
            head_e.op2      = cdb_value;
        end
`endif
        case (head_e.cls)
            DISP_LSQ: head_stall = lsq_stall;
            DISP_CSR: head_stall = csr_stall;
            default:  head_stall = exers_stall;
        endcase
        dispatch         = !empty && !rob_flush && !rst && !head_stall;
        disp_exers_write = dispatch && (head_e.cls == DISP_EXE);
        disp_lsq_write   = dispatch && (head_e.cls == DISP_LSQ);
        disp_csr_write   = dispatch && (head_e.cls == DISP_CSR);
        disp_op          = empty ? '0 : head_e.op;
        disp_robid       = empty ? '0 : head_e.robid;
        disp_rd          = empty ? '0 : head_e.rd;
        disp_imm         = empty ? '0 : head_e.imm;
        disp_op1ready    = empty ? 1'b0 : head_e.op1ready;
        disp_op2ready    = empty ? 1'b0 : head_e.op2ready;
        disp_op1         = empty ? '0 : head_e.op1;
        disp_op2         = empty ? '0 : head_e.op2;
    end

    // Pointer, count and valid-bit updates; flush empties the buffer outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (rob_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (accept) begin
                tail_d          = tail_q + PTR_W'(1);
                valid_d[tail_q] = 1'b1;
            end
            if (dispatch) begin
                head_d          = head_q + PTR_W'(1);
                valid_d[head_q] = 1'b0;
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(dispatch);
        end
    end

    // Entry storage: snooped contents, with the accepted instruction written at the tail.
    always_comb begin
        mem_d = snp_entry;
        if (accept) begin
            mem_d[tail_q] = new_entry;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload register; contents are qualified by valid_q and count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
